// File: rtl/adder_sum_accumulator_if.sv
// Bus bundle for the adder sum accumulator: the incoming sum channel
// (with its flush side-band) and the outgoing block-result channel.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid && ready are both high. The producer holds valid and
// its payload stable until that transfer. Ready may be asserted without
// valid. Neither side's ready may depend combinationally on valid.
interface adder_sum_accumulator_if #(
    parameter int SUM_W = 9,
    parameter int ACC_W = 16
);
    logic             sum_valid;
    logic             sum_ready;
    logic [SUM_W-1:0] sum_in;
    logic             flush;
    logic             acc_valid;
    logic             acc_ready;
    logic [ACC_W-1:0] acc_out;
    logic [7:0]       acc_cnt;
    logic             acc_sat;

    // Upstream producer / downstream consumer side (the environment)
    modport master (
        output sum_valid, sum_in, flush, acc_ready,
        input  sum_ready, acc_valid, acc_out, acc_cnt, acc_sat
    );

    // Accumulator side
    modport slave (
        input  sum_valid, sum_in, flush, acc_ready,
        output sum_ready, acc_valid, acc_out, acc_cnt, acc_sat
    );
endinterface

// File: rtl/adder_sum_accumulator.sv
// Adder sum accumulator: sums blocks of BLOCK_LEN unsigned adder results
// (or a shorter block closed early by flush) into a saturating ACC_W-bit
// total, then offers {total, count, saturated} downstream. All outputs
// are registered; state_dbg exposes the FSM state (0 = ACCUM, 1 = HOLD).
module adder_sum_accumulator #(
    parameter int SUM_W     = 9,
    parameter int ACC_W     = 16,
    parameter int BLOCK_LEN = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    adder_sum_accumulator_if.slave  bus,
    output logic                    state_dbg
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [7:0] BLOCK_CNT = 8'(BLOCK_LEN);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [ACC_W-1:0] out_q, out_d;
    logic [7:0]       ocnt_q, ocnt_d;
    logic             osat_q, osat_d;

    logic             accept;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] acc_upd;
    logic [7:0]       cnt_upd;
    logic             sat_upd;
    logic             close;

    // Candidate post-accept values: one extra bit catches the carry out,
    // which clamps the total to all-ones and marks the block saturated.
    always_comb begin
        accept   = bus.sum_valid && ready_q;
        sum_wide = {1'b0, acc_q} + {{(ACC_W + 1 - SUM_W){1'b0}}, bus.sum_in};
        acc_upd  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
        cnt_upd  = cnt_q + 8'd1;
        sat_upd  = sat_q | sum_wide[ACC_W];
    end

    // Next-state and next-register logic; every register holds by default
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        ready_d = ready_q;
        valid_d = valid_q;
        out_d   = out_q;
        ocnt_d  = ocnt_q;
        osat_d  = osat_q;
        close   = 1'b0;
        case (state_q)
            ACCUM: begin
                // ready comes up on the first edge after reset release
                ready_d = 1'b1;
                if (accept) begin
                    acc_d = acc_upd;
                    cnt_d = cnt_upd;
                    sat_d = sat_upd;
                end
                // A flush with nothing accumulated and no accept is a no-op
                close = (accept && (cnt_upd == BLOCK_CNT)) ||
                        (bus.flush && ((cnt_q != 8'd0) || accept));
                if (close) begin
                    out_d   = accept ? acc_upd : acc_q;
                    ocnt_d  = accept ? cnt_upd : cnt_q;
                    osat_d  = accept ? sat_upd : sat_q;
                    valid_d = 1'b1;
                    ready_d = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Result is frozen until the downstream takes it
                if (valid_q && bus.acc_ready) begin
                    valid_d = 1'b0;
                    acc_d   = '0;
                    cnt_d   = 8'd0;
                    sat_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State and datapath registers; reset discards any partial block
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= 8'd0;
            sat_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
            ocnt_q  <= 8'd0;
            osat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            ocnt_q  <= ocnt_d;
            osat_q  <= osat_d;
        end
    end

    assign bus.sum_ready = ready_q;
    assign bus.acc_valid = valid_q;
    assign bus.acc_out   = out_q;
    assign bus.acc_cnt   = ocnt_q;
    assign bus.acc_sat   = osat_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Bench for adder_sum_accumulator. Instance a uses the default widths;
// instance b uses ACC_W=10 so that four maximal sums saturate.
// Expected block results are pushed before each block is driven; a
// monitor per instance pops and compares on every result handshake.
module tb_adder_sum_accumulator;

    localparam int W = 25; // {sat, cnt[7:0], out[15:0]}

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    adder_sum_accumulator_if #(.SUM_W(9), .ACC_W(16)) a_if ();
    adder_sum_accumulator_if #(.SUM_W(9), .ACC_W(10)) b_if ();
    logic a_dbg, b_dbg;

    adder_sum_accumulator #(.SUM_W(9), .ACC_W(16), .BLOCK_LEN(4)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.slave), .state_dbg(a_dbg)
    );
    adder_sum_accumulator #(.SUM_W(9), .ACC_W(10), .BLOCK_LEN(4)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.slave), .state_dbg(b_dbg)
    );

    int checks = 0;
    int failures = 0;
    int zero_cnt = 0;
    logic cnt_en = 1'b0;
    logic [W-1:0] exp_qa[$];
    logic [W-1:0] exp_qb[$];
    logic [W-1:0] ea, eb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic exp_push(input bit sel, input int out, input int cnt, input bit sat);
        logic [W-1:0] e;
        e = {sat, cnt[7:0], out[15:0]};
        if (sel) exp_qb.push_back(e);
        else     exp_qa.push_back(e);
    endtask

    // Present one sum (optionally with flush) and hold it until accepted
    task automatic send(input bit sel, input int val, input bit fl);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        if (sel) begin b_if.sum_valid = 1'b1; b_if.sum_in = val[8:0]; b_if.flush = fl; end
        else     begin a_if.sum_valid = 1'b1; a_if.sum_in = val[8:0]; a_if.flush = fl; end
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = sel ? b_if.sum_ready : a_if.sum_ready;
            n++;
        end
        @(posedge clk);
        #1;
        if (sel) begin b_if.sum_valid = 1'b0; b_if.flush = 1'b0; end
        else     begin a_if.sum_valid = 1'b0; a_if.flush = 1'b0; end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: sum %0d never accepted within 50 cycles", val);
        end
    endtask

    // Wait (bounded) until instance a is ready for a new sum
    task automatic wait_ready_a();
        int n;
        n = 0;
        while (a_if.sum_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_ready_a", a_if.sum_ready, 1);
    endtask

    // Result monitor, instance a
    always @(negedge clk) begin
        if (reset && a_if.acc_valid && a_if.acc_ready) begin
            if (exp_qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected: got out=%0d cnt=%0d with nothing expected",
                         a_if.acc_out, a_if.acc_cnt);
            end else begin
                ea = exp_qa.pop_front();
                check("a_acc_out", a_if.acc_out, ea[15:0]);
                check("a_acc_cnt", a_if.acc_cnt, ea[23:16]);
                check("a_acc_sat", a_if.acc_sat, ea[24]);
            end
        end
    end

    // Result monitor, instance b
    always @(negedge clk) begin
        if (reset && b_if.acc_valid && b_if.acc_ready) begin
            if (exp_qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected: got out=%0d cnt=%0d with nothing expected",
                         b_if.acc_out, b_if.acc_cnt);
            end else begin
                eb = exp_qb.pop_front();
                check("b_acc_out", b_if.acc_out, eb[15:0]);
                check("b_acc_cnt", b_if.acc_cnt, eb[23:16]);
                check("b_acc_sat", b_if.acc_sat, eb[24]);
            end
        end
    end

    // Bubble counter for the throughput test
    always @(negedge clk) begin
        if (cnt_en && !a_if.sum_ready) zero_cnt++;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_if.sum_valid = 1'b0; a_if.sum_in = '0; a_if.flush = 1'b0; a_if.acc_ready = 1'b1;
        b_if.sum_valid = 1'b0; b_if.sum_in = '0; b_if.flush = 1'b0; b_if.acc_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sum_ready", a_if.sum_ready, 0);
        check("rst_acc_valid", a_if.acc_valid, 0);
        check("rst_acc_out", a_if.acc_out, 0);
        check("rst_acc_cnt", a_if.acc_cnt, 0);
        check("rst_acc_sat", a_if.acc_sat, 0);
        check("rst_state", a_dbg, 0);
        reset = 1'b1;
        #1;
        check("rel_ready_low", a_if.sum_ready, 0);
        @(posedge clk);
        #1;
        check("rel_ready_high", a_if.sum_ready, 1);

        // 1: basic block 10+20+30+40
        exp_push(0, 100, 4, 0);
        send(0, 10, 0);
        send(0, 20, 0);
        send(0, 30, 0);
        check("t1_valid_before", a_if.acc_valid, 0);
        send(0, 40, 0);
        check("t1_valid_latency", a_if.acc_valid, 1);
        check("t1_state_hold", a_dbg, 1);
        check("t1_ready_low", a_if.sum_ready, 0);

        // 2: saturation on the 10-bit instance, then a clean block
        exp_push(1, 1023, 4, 1);
        for (int i = 0; i < 4; i++) send(1, 511, 0);
        exp_push(1, 10, 4, 0);
        for (int i = 1; i <= 4; i++) send(1, i, 0);

        // 3: downstream stalls for 5 cycles
        wait_ready_a();
        a_if.acc_ready = 1'b0;
        exp_push(0, 10, 4, 0);
        for (int i = 1; i <= 4; i++) send(0, i, 0);
        a_if.sum_valid = 1'b1;
        a_if.sum_in = 9'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_out_stable", a_if.acc_out, 10);
            check("t3_valid_held", a_if.acc_valid, 1);
            check("t3_ready_low", a_if.sum_ready, 0);
            @(posedge clk);
            #1;
        end
        a_if.sum_valid = 1'b0;
        a_if.acc_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t3_valid_drop", a_if.acc_valid, 0);
        check("t3_ready_back", a_if.sum_ready, 1);

        // 4a: flush without a sum closes a 2-sum block
        exp_push(0, 7, 2, 0);
        send(0, 3, 0);
        send(0, 4, 0);
        a_if.flush = 1'b1;
        @(posedge clk);
        #1;
        a_if.flush = 1'b0;
        check("t4_flush_close", a_if.acc_valid, 1);
        // 4b: flush on an empty block does nothing
        @(posedge clk);
        #1;
        wait_ready_a();
        a_if.flush = 1'b1;
        @(posedge clk);
        #1;
        a_if.flush = 1'b0;
        check("t4_idle_flush_valid", a_if.acc_valid, 0);
        check("t4_idle_flush_state", a_dbg, 0);
        // 4c: flush with the 3rd accept of 5, remainder flushed too
        exp_push(0, 18, 3, 0);
        send(0, 5, 0);
        send(0, 6, 0);
        send(0, 7, 1);
        exp_push(0, 17, 2, 0);
        send(0, 8, 0);
        send(0, 9, 1);

        // 5: reset in the middle of a block
        send(0, 1, 0);
        send(0, 2, 0);
        #2;
        reset = 1'b0;
        #1;
        check("t5_rst_ready", a_if.sum_ready, 0);
        check("t5_rst_valid", a_if.acc_valid, 0);
        check("t5_rst_out", a_if.acc_out, 0);
        check("t5_rst_cnt", a_if.acc_cnt, 0);
        check("t5_rst_sat", a_if.acc_sat, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_push(0, 4, 4, 0);
        for (int i = 0; i < 4; i++) send(0, 1, 0);

        // 6: three back-to-back blocks, one bubble each
        @(posedge clk);
        #1;
        wait_ready_a();
        zero_cnt = 0;
        cnt_en = 1'b1;
        exp_push(0, 10, 4, 0);
        exp_push(0, 26, 4, 0);
        exp_push(0, 42, 4, 0);
        for (int i = 1; i <= 12; i++) send(0, i, 0);
        repeat (3) @(posedge clk);
        #1;
        cnt_en = 1'b0;
        check("t6_bubbles", zero_cnt, 3);

        // Every expected result must have been seen
        for (int n = 0; n < 20 && (exp_qa.size() + exp_qb.size()) != 0; n++) @(posedge clk);
        check("queues_drained", exp_qa.size() + exp_qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
